oled_sequencer: RTL and testbench
=================================

// Module: oled_sequencer
// PURPOSE
//  Sequences the 8-bit SPI byte engine for an SSD1306 panel: pulses panel reset, streams the init
//  command list from an external ROM, then on request sends an address-window preamble and a full
//  framebuffer. Drives D/C, per-byte start and the CS-release flag. Sits between the framebuffer
//  RAM / init ROM and the spi instance.
// PARAMETERS
//  INIT_LEN   25      number of init command bytes in ROM (>=1)
//  COLS       128     display columns
//  PAGES      8       display pages (8 rows each)
//  RST_CYCLES 1000    clk cycles for panel-reset low pulse and for post-reset wait
// PORTS
//  clk_in            in   1    clock
//  reset_in          in   1    synchronous reset, active-high
//  refresh_req_in    in   1    request one full-frame transfer (level or pulse)
//  busy_out          out  1    1 while resetting, initialising or transferring a frame
//  init_done_out     out  1    1 once init list fully sent; cleared only by reset
//  rom_addr_out      out  $clog2(INIT_LEN)       init ROM address; rom_data_in valid same cycle
//  rom_data_in       in   8    init command byte
//  fb_addr_out       out  $clog2(COLS*PAGES)     framebuffer address (page*COLS+col)
//  fb_data_in        in   8    framebuffer byte, valid 1 cycle after fb_addr_out
//  spi_tx_start_out  out  1    one-cycle start pulse to spi
//  spi_deact_cs_out  out  1    release CS after this byte (valid with start)
//  spi_data_out      out  8    byte to send (held stable from start until tx_done rises)
//  spi_tx_done_in    in   1    spi idle/ready (high when it can accept a byte)
//  oled_rst_out      out  1    panel RES#, active-low
//  oled_dc_out       out  1    panel D/C: 0 command, 1 data
// BEHAVIOUR
//  - Reset values: oled_rst_out=0, oled_dc_out=0, spi_tx_start_out=0, spi_deact_cs_out=0,
//    spi_data_out=0, busy_out=1, init_done_out=0, all addresses 0, pending=0, state RST_LOW.
//  - States: RST_LOW -> RST_WAIT -> INIT_SEND/INIT_WAIT -> IDLE -> PRE_SEND/PRE_WAIT ->
//    FB_FETCH -> FB_SEND/FB_WAIT -> IDLE.
//  - RST_LOW: oled_rst_out=0 for exactly RST_CYCLES clocks; RST_WAIT: oled_rst_out=1 for RST_CYCLES.
//  - *_SEND: entered only when spi_tx_done_in=1; drives start=1 for exactly one cycle with data,
//    dc and deact_cs registered in the same cycle; next state *_WAIT.
//  - *_WAIT: must first see spi_tx_done_in=0 (busy_seen flag), then spi_tx_done_in=1 ends the byte;
//    tx_done still high in the cycle right after start is NOT completion. Then advance index.
//  - INIT: dc=0, bytes rom_data_in for addr 0..INIT_LEN-1; deact_cs=1 on last byte only.
//    After last byte: init_done_out=1, busy_out=0, IDLE.
//  - IDLE: refresh_req_in or pending -> busy_out=1, clear pending, PRE_SEND.
//  - PRE: dc=0, fixed 6 bytes 0x21,0x00,COLS-1,0x22,0x00,PAGES-1; deact_cs=1 on 6th byte.
//  - FB_FETCH: present fb_addr_out, wait 1 cycle for fb_data_in, then FB_SEND with dc=1.
//    Addresses 0..COLS*PAGES-1 in order; deact_cs=1 on last byte only; then IDLE, busy_out=0.
//  - refresh_req_in while busy (incl. before init_done) sets pending (depth 1; extra requests
//    merge). Pending is served immediately on return to IDLE.
//  - spi_data_out/dc/deact_cs hold their values until the next start; never change mid-byte.
//  - reset_in mid-operation: immediate return to reset values, full reset+init sequence reruns,
//    pending and any partial frame discarded.
//  - Counters sized by $clog2; RST counter counts to RST_CYCLES-1 then wraps to 0 on state change.
// TESTING
//  1 reset, RST_CYCLES=10 -> oled_rst_out low 10 clk, high 10 clk, first start on cycle 21+.
//  2 spi model 18 clk/byte, ROM[i]=i+0x80 -> 25 bytes 0x80..0x98, dc=0, deact_cs only on 0x98.
//  3 refresh pulse after init -> 0x21,0x00,0x7F,0x22,0x00,0x07 dc=0 then 1024 fb bytes dc=1,
//    last byte deact_cs=1, busy_out falls after last tx_done rise.
//  4 refresh_req pulsed 3x during frame -> exactly one further frame follows, then idle.
//  5 spi_tx_done_in held high 1 cycle after start -> no double-count, no extra start pulse.
//  6 reset_in at fb byte 500 -> outputs at reset values next cycle; init list resent from byte 0.

Source files
------------

// File: rtl/oled_sequencer_if.sv
// SPI byte-engine handshake between the panel sequencer (master) and the spi core (slave).
interface oled_sequencer_if;
  logic       spi_tx_start_out;
  logic       spi_deact_cs_out;
  logic [7:0] spi_data_out;
  logic       spi_tx_done_in;

  modport master (
    output spi_tx_start_out,
    output spi_deact_cs_out,
    output spi_data_out,
    input  spi_tx_done_in
  );

  modport slave (
    input  spi_tx_start_out,
    input  spi_deact_cs_out,
    input  spi_data_out,
    output spi_tx_done_in
  );
endinterface

// File: rtl/oled_sequencer.sv
// SSD1306 sequencer: panel reset pulse, init list from ROM, then window preamble + framebuffer per refresh.
// One byte in flight at a time; each byte waits for the spi core to go busy and return idle.
module oled_sequencer #(
  parameter int INIT_LEN   = 25,
  parameter int COLS       = 128,
  parameter int PAGES      = 8,
  parameter int RST_CYCLES = 1000,
  localparam int RW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1,
  localparam int FW = (COLS * PAGES > 1) ? $clog2(COLS * PAGES) : 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             refresh_req_in,
  output logic             busy_out,
  output logic             init_done_out,
  output logic [RW-1:0]    rom_addr_out,
  input  logic [7:0]       rom_data_in,
  output logic [FW-1:0]    fb_addr_out,
  input  logic [7:0]       fb_data_in,
  oled_sequencer_if.master spi,
  output logic             oled_rst_out,
  output logic             oled_dc_out
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_MAX  = CW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] ROM_LAST = RW'(INIT_LEN - 1);
  localparam logic [FW-1:0] FB_LAST  = FW'(COLS * PAGES - 1);

  typedef enum logic [3:0] {
    RST_LOW, RST_WAIT, INIT_SEND, INIT_WAIT, IDLE,
    PRE_SEND, PRE_WAIT, FB_FETCH, FB_SEND, FB_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic [RW-1:0] rom_addr_q, rom_addr_d;
  logic [FW-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]    pre_idx_q, pre_idx_d;
  logic          busy_seen_q, busy_seen_d;
  logic          fetch_ph_q, fetch_ph_d;
  logic          pending_q, pending_d;
  logic          start_q, start_d;
  logic          deact_q, deact_d;
  logic [7:0]    data_q, data_d;
  logic          dc_q, dc_d;
  logic          oled_rst_q, oled_rst_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          byte_done;

  function automatic logic [7:0] pre_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h21;
      3'd2:    return 8'(COLS - 1);
      3'd3:    return 8'h22;
      3'd5:    return 8'(PAGES - 1);
      default: return 8'h00;
    endcase
  endfunction

  // A byte is finished only once the engine has been seen busy and is idle again.
  assign byte_done = busy_seen_q & spi.spi_tx_done_in;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    rom_addr_d  = rom_addr_q;
    fb_addr_d   = fb_addr_q;
    pre_idx_d   = pre_idx_q;
    busy_seen_d = busy_seen_q;
    fetch_ph_d  = fetch_ph_q;
    pending_d   = pending_q | refresh_req_in;
    start_d     = 1'b0;
    deact_d     = deact_q;
    data_d      = data_q;
    dc_d        = dc_q;
    oled_rst_d  = oled_rst_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;

    case (state_q)
      RST_LOW: begin
        if (rst_cnt_q == RST_MAX) begin
          rst_cnt_d  = '0;
          oled_rst_d = 1'b1;
          state_d    = RST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RST_WAIT: begin
        if (rst_cnt_q != RST_MAX) begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end else if (spi.spi_tx_done_in) begin
          rst_cnt_d = '0;
          state_d   = INIT_SEND;
          start_d   = 1'b1;
          data_d    = rom_data_in;
          dc_d      = 1'b0;
          deact_d   = (rom_addr_q == ROM_LAST);
        end
      end
      INIT_SEND: begin
        // Step the ROM address now so the next byte is already on rom_data_in at completion.
        busy_seen_d = 1'b0;
        state_d     = INIT_WAIT;
        if (rom_addr_q != ROM_LAST) begin
          rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      INIT_WAIT: begin
        if (!spi.spi_tx_done_in) begin
          busy_seen_d = 1'b1;
        end else if (byte_done) begin
          if (deact_q) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d = INIT_SEND;
            start_d = 1'b1;
            data_d  = rom_data_in;
            dc_d    = 1'b0;
            deact_d = (rom_addr_q == ROM_LAST);
          end
        end
      end
      IDLE: begin
        if ((refresh_req_in || pending_q) && spi.spi_tx_done_in) begin
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = PRE_SEND;
          start_d   = 1'b1;
          data_d    = pre_byte(pre_idx_q);
          dc_d      = 1'b0;
          deact_d   = 1'b0;
        end
      end
      PRE_SEND: begin
        busy_seen_d = 1'b0;
        pre_idx_d   = pre_idx_q + 1'b1;
        state_d     = PRE_WAIT;
      end
      PRE_WAIT: begin
        if (!spi.spi_tx_done_in) begin
          busy_seen_d = 1'b1;
        end else if (byte_done) begin
          if (deact_q) begin
            state_d    = FB_FETCH;
            pre_idx_d  = '0;
            fetch_ph_d = 1'b0;
            fb_addr_d  = '0;
          end else begin
            state_d = PRE_SEND;
            start_d = 1'b1;
            data_d  = pre_byte(pre_idx_q);
            dc_d    = 1'b0;
            deact_d = (pre_idx_q == 3'd5);
          end
        end
      end
      FB_FETCH: begin
        // First cycle presents the address; RAM data is usable in the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else if (spi.spi_tx_done_in) begin
          fetch_ph_d = 1'b0;
          state_d    = FB_SEND;
          start_d    = 1'b1;
          data_d     = fb_data_in;
          dc_d       = 1'b1;
          deact_d    = (fb_addr_q == FB_LAST);
        end
      end
      FB_SEND: begin
        busy_seen_d = 1'b0;
        state_d     = FB_WAIT;
      end
      FB_WAIT: begin
        if (!spi.spi_tx_done_in) begin
          busy_seen_d = 1'b1;
        end else if (byte_done) begin
          if (deact_q) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            fb_addr_d = '0;
          end else begin
            state_d   = FB_FETCH;
            fb_addr_d = fb_addr_q + 1'b1;
          end
        end
      end
      default: state_d = RST_LOW;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= RST_LOW;
      rst_cnt_q   <= '0;
      rom_addr_q  <= '0;
      fb_addr_q   <= '0;
      pre_idx_q   <= '0;
      busy_seen_q <= 1'b0;
      fetch_ph_q  <= 1'b0;
      pending_q   <= 1'b0;
      start_q     <= 1'b0;
      deact_q     <= 1'b0;
      data_q      <= '0;
      dc_q        <= 1'b0;
      oled_rst_q  <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      rom_addr_q  <= rom_addr_d;
      fb_addr_q   <= fb_addr_d;
      pre_idx_q   <= pre_idx_d;
      busy_seen_q <= busy_seen_d;
      fetch_ph_q  <= fetch_ph_d;
      pending_q   <= pending_d;
      start_q     <= start_d;
      deact_q     <= deact_d;
      data_q      <= data_d;
      dc_q        <= dc_d;
      oled_rst_q  <= oled_rst_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign busy_out             = busy_q;
  assign init_done_out        = init_done_q;
  assign rom_addr_out         = rom_addr_q;
  assign fb_addr_out          = fb_addr_q;
  assign spi.spi_tx_start_out = start_q;
  assign spi.spi_deact_cs_out = deact_q;
  assign spi.spi_data_out     = data_q;
  assign oled_rst_out         = oled_rst_q;
  assign oled_dc_out          = dc_q;

endmodule

// File: tb/tb_oled_sequencer.sv
// Bench for oled_sequencer: randomized spi timing and framebuffer contents against an expected byte stream.
module tb_oled_sequencer;
  localparam int INIT_LEN   = 25;
  localparam int COLS       = 128;
  localparam int PAGES      = 8;
  localparam int RST_CYCLES = 10;
  localparam int FB_LEN     = COLS * PAGES;

  logic       clk_in;
  logic       reset_in;
  logic       refresh_req_in;
  logic       busy_out;
  logic       init_done_out;
  logic [4:0] rom_addr_out;
  logic [7:0] rom_data_in;
  logic [9:0] fb_addr_out;
  logic [7:0] fb_data_in;
  logic       oled_rst_out;
  logic       oled_dc_out;

  oled_sequencer_if spi_bus();

  oled_sequencer #(
    .INIT_LEN(INIT_LEN), .COLS(COLS), .PAGES(PAGES), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .refresh_req_in(refresh_req_in),
    .busy_out(busy_out),
    .init_done_out(init_done_out),
    .rom_addr_out(rom_addr_out),
    .rom_data_in(rom_data_in),
    .fb_addr_out(fb_addr_out),
    .fb_data_in(fb_data_in),
    .spi(spi_bus),
    .oled_rst_out(oled_rst_out),
    .oled_dc_out(oled_dc_out)
  );

  // Stream entries are {dc, deact_cs, data}.
  logic [7:0] fb_mem [0:FB_LEN-1];
  logic [9:0] exp_q[$];
  logic [9:0] cap_log[$];
  int n_vec;
  int n_err;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #950000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  assign rom_data_in = 8'h80 + {3'b000, rom_addr_out};

  // Synchronous framebuffer RAM: data for an address appears one clock later.
  initial begin
    logic [9:0] a_lat;
    a_lat = '0;
    fb_data_in = 8'h00;
    forever begin
      @(negedge clk_in);
      a_lat = fb_addr_out;
      @(posedge clk_in);
      #1;
      fb_data_in = fb_mem[a_lat];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_init();
    for (int i = 0; i < INIT_LEN; i++)
      exp_q.push_back({1'b0, (i == INIT_LEN - 1), 8'(8'h80 + i)});
  endtask

  task automatic exp_frame();
    logic [7:0] pre [0:5];
    pre[0] = 8'h21; pre[1] = 8'h00; pre[2] = 8'(COLS - 1);
    pre[3] = 8'h22; pre[4] = 8'h00; pre[5] = 8'(PAGES - 1);
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, (i == 5), pre[i]});
    for (int a = 0; a < FB_LEN; a++) exp_q.push_back({1'b1, (a == FB_LEN - 1), fb_mem[a]});
  endtask

  // Spi engine model and the per-cycle compare of everything the sequencer presents to it.
  initial begin
    logic [9:0] cap;
    int hold, len;
    bit aborted;
    spi_bus.spi_tx_done_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      if (!reset_in && spi_bus.spi_tx_start_out) begin
        cap = {oled_dc_out, spi_bus.spi_deact_cs_out, spi_bus.spi_data_out};
        cap_log.push_back(cap);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_start actual=%0h required=none", cap);
        end else begin
          chk("spi_byte", cap, exp_q.pop_front());
        end
        chk("busy_during_byte", busy_out, 1);
        hold = $urandom_range(1, 2);
        len = init_done_out ? $urandom_range(1, 4) : 16;
        aborted = 0;
        for (int k = 0; k < hold + len && !aborted; k++) begin
          @(posedge clk_in);
          #1;
          if (reset_in) begin
            aborted = 1;
          end else begin
            chk("single_start", spi_bus.spi_tx_start_out, 0);
            chk("byte_hold", {oled_dc_out, spi_bus.spi_deact_cs_out, spi_bus.spi_data_out}, cap);
            if (k == hold - 1) spi_bus.spi_tx_done_in = 1'b0;
          end
        end
        spi_bus.spi_tx_done_in = 1'b1;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_oled_rst", oled_rst_out, 0);
    chk("rst_dc", oled_dc_out, 0);
    chk("rst_start", spi_bus.spi_tx_start_out, 0);
    chk("rst_deact", spi_bus.spi_deact_cs_out, 0);
    chk("rst_data", spi_bus.spi_data_out, 0);
    chk("rst_busy", busy_out, 1);
    chk("rst_init_done", init_done_out, 0);
    chk("rst_rom_addr", rom_addr_out, 0);
    chk("rst_fb_addr", fb_addr_out, 0);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && !busy_out && spi_bus.spi_tx_done_in) break;
    end
    chk(tag, {exp_q.size() == 0, busy_out}, 2'b10);
  endtask

  task automatic wait_caps(input int target, input int max_cyc, input string tag);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_in);
      if (cap_log.size() >= target) break;
    end
    chk(tag, cap_log.size() >= target, 1);
  endtask

  task automatic pulse_req();
    @(negedge clk_in);
    refresh_req_in = 1'b1;
    @(negedge clk_in);
    refresh_req_in = 1'b0;
  endtask

  initial begin
    int lo, hi, base;
    logic [9:0] pre_lit [0:5];
    n_vec = 0;
    n_err = 0;
    reset_in = 1'b1;
    refresh_req_in = 1'b0;
    for (int a = 0; a < FB_LEN; a++) fb_mem[a] = 8'($urandom);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_vals();

    // Panel reset pulse and init list
    exp_init();
    reset_in = 1'b0;
    lo = 0;
    hi = 0;
    for (int c = 0; c < 100; c++) begin
      if (spi_bus.spi_tx_start_out) break;
      if (oled_rst_out) hi++;
      else lo++;
      @(negedge clk_in);
    end
    chk("first_start_seen", spi_bus.spi_tx_start_out, 1);
    chk("rst_low_cycles", lo, RST_CYCLES);
    chk("rst_high_cycles", hi, RST_CYCLES);
    wait_idle(5000, "init_idle");
    chk("init_done", init_done_out, 1);
    chk("init_count", cap_log.size(), INIT_LEN);
    chk("init_first", cap_log[0], 10'h080);
    chk("init_second_last_deact", cap_log[23][8], 0);
    chk("init_last", cap_log[24], 10'h198);

    // Single frame on one refresh pulse
    base = cap_log.size();
    exp_frame();
    pulse_req();
    wait_idle(20000, "frame1_idle");
    pre_lit[0] = 10'h021; pre_lit[1] = 10'h000; pre_lit[2] = 10'h07F;
    pre_lit[3] = 10'h022; pre_lit[4] = 10'h000; pre_lit[5] = 10'h107;
    for (int i = 0; i < 6; i++) chk("preamble_literal", cap_log[base + i], pre_lit[i]);
    chk("frame1_count", cap_log.size(), base + 6 + FB_LEN);
    chk("frame1_last_flags", cap_log[base + 5 + FB_LEN][9:8], 2'b11);

    // Three requests during a frame merge into one more frame
    for (int a = 0; a < FB_LEN; a++) fb_mem[a] = 8'($urandom);
    base = cap_log.size();
    exp_frame();
    exp_frame();
    pulse_req();
    wait_caps(base + 100, 3000, "frame2_progress");
    pulse_req();
    repeat (150) @(negedge clk_in);
    pulse_req();
    repeat (150) @(negedge clk_in);
    pulse_req();
    wait_idle(30000, "merged_idle");
    repeat (300) @(negedge clk_in);
    chk("merged_count", cap_log.size(), base + 2 * (6 + FB_LEN));
    chk("merged_busy_low", busy_out, 0);

    // Reset mid-frame, then a request before init completes
    for (int a = 0; a < FB_LEN; a++) fb_mem[a] = 8'($urandom);
    base = cap_log.size();
    exp_frame();
    pulse_req();
    wait_caps(base + 6 + 500, 10000, "frame4_progress");
    reset_in = 1'b1;
    exp_q.delete();
    @(posedge clk_in);
    @(negedge clk_in);
    check_reset_vals();
    base = cap_log.size();
    reset_in = 1'b0;
    exp_init();
    exp_frame();
    pulse_req();
    wait_idle(25000, "post_reset_idle");
    chk("post_reset_first", cap_log[base], 10'h080);
    chk("post_reset_count", cap_log.size(), base + INIT_LEN + 6 + FB_LEN);
    chk("post_reset_init_done", init_done_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
